// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage pipelined two-level carry-lookahead adder/subtractor
// Optional signed-overflow output: define CLA_OVF_FLAG_EN.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NGRP = WIDTH / GROUP;

    generate
        if ((WIDTH % GROUP) != 0) begin : g_width_check
            $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    logic s2_en;
    logic s1_en;
    logic s1_valid;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // Stage 1 inputs: operand conditioning, bit and group propagate/generate.
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NGRP-1:0]  pg_in;
    logic [NGRP-1:0]  gg_in;
    logic             gg_acc;

    always_comb begin
        b_eff  = in_sub ? ~in_b : in_b;
        c0_in  = in_sub ^ in_cin;
        p_in   = in_a ^ b_eff;
        g_in   = in_a & b_eff;
        pg_in  = '0;
        gg_in  = '0;
        gg_acc = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            pg_in[k] = &p_in[k*GROUP +: GROUP];
            gg_acc   = 1'b0;
            for (int i = 0; i < GROUP; i++) begin
                gg_acc = g_in[k*GROUP+i] | (p_in[k*GROUP+i] & gg_acc);
            end
            gg_in[k] = gg_acc;
        end
    end

    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NGRP-1:0]  s1_pg;
    logic [NGRP-1:0]  s1_gg;
    logic             s1_c0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_pg    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p  <= p_in;
                s1_g  <= g_in;
                s1_pg <= pg_in;
                s1_gg <= gg_in;
                s1_c0 <= c0_in;
            end
        end
    end

    // Group carries in flattened sum-of-products form, so no carry ripples
    // from one group into the next.
    logic [NGRP:0]    grp_c;
    logic [WIDTH-1:0] c_bit;
    logic             sop_acc;
    logic             sop_term;
    logic             c_run;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;

    always_comb begin
        grp_c    = '0;
        grp_c[0] = s1_c0;
        sop_acc  = 1'b0;
        sop_term = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            sop_term = s1_c0;
            for (int m = 0; m <= k; m++) begin
                sop_term = sop_term & s1_pg[m];
            end
            sop_acc = sop_term;
            for (int j = 0; j <= k; j++) begin
                sop_term = s1_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    sop_term = sop_term & s1_pg[m];
                end
                sop_acc = sop_acc | sop_term;
            end
            grp_c[k+1] = sop_acc;
        end

        c_bit = '0;
        c_run = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            c_run = grp_c[k];
            for (int i = 0; i < GROUP; i++) begin
                c_bit[k*GROUP+i] = c_run;
                c_run = s1_g[k*GROUP+i] | (s1_p[k*GROUP+i] & c_run);
            end
        end

        sum_nxt  = s1_p ^ c_bit;
        cout_nxt = grp_c[NGRP];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
            out_ovf   <= 1'b0;
`endif
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_nxt;
                out_cout <= cout_nxt;
`ifdef CLA_OVF_FLAG_EN
                out_ovf  <= c_bit[WIDTH-1] ^ cout_nxt;
`endif
            end
        end
    end

endmodule
